// File: rtl/aes128_dec_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes128_dec_iter
// Purpose  : Iterative AES-128 inverse cipher. One shared round datapath is
//            clocked once per round. The round-10 key is rebuilt by running
//            the forward key schedule (KEYX), then the rounds walk the
//            schedule backwards (ROUND) alongside the inverse rounds.
// Ports    : clk       - clock, rising edge
//            rst_n     - synchronous active-low reset
//            in_valid  - ciphertext/key offered
//            in_ready  - block can accept (IDLE only)
//            data      - ciphertext, byte 0 = bits [0:7], column-major
//            key       - cipher key (round-0 key)
//            out_valid - plaintext available
//            out_ready - consumer takes plaintext
//            de_data   - plaintext, held until next result or reset
// Options  : AES_DEC_KEY_CACHE_EN - remembers the last key and its round-10
//            key so that a repeated key skips KEYX (latency 10 instead of 20).
// Revision : 1.0 - initial release
// ============================================================================
module aes128_dec_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] data,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] de_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_KEYX  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers. The S-boxes are computed from the field inverse and the
  // affine map rather than stored, so there is no table to mistype.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 = a^-1 (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [0:31] sub_rot(input logic [0:31] w);
    return {sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31]), sbox(w[0:7])};
  endfunction

  function automatic logic [0:127] next_key(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] w0, w1, w2, w3;
    w0 = k[0:31] ^ sub_rot(k[96:127]) ^ {rc, 24'h0};
    w1 = k[32:63] ^ w0;
    w2 = k[64:95] ^ w1;
    w3 = k[96:127] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one key-schedule step: recover the upper words first, then w0.
  function automatic logic [0:127] inv_key(input logic [0:127] k, input logic [7:0] rc);
    logic [0:31] w0, w1, w2, w3;
    w3 = k[96:127] ^ k[64:95];
    w2 = k[64:95] ^ k[32:63];
    w1 = k[32:63] ^ k[0:31];
    w0 = k[0:31] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows followed by InvSubBytes: row r rotates right by r columns.
  function automatic logic [0:127] inv_sub_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = inv_sbox(s[8*(4*((c - r) & 3) + r) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   b0, b1, b2, b3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      b0 = s[32*c      +: 8];
      b1 = s[32*c + 8  +: 8];
      b2 = s[32*c + 16 +: 8];
      b3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09);
      o[32*c + 8  +: 8] = gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d);
      o[32*c + 16 +: 8] = gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b);
      o[32*c + 24 +: 8] = gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e);
    end
    return o;
  endfunction

  // --------------------------------------------------------------------------
  // Registers and datapath
  // --------------------------------------------------------------------------
  state_t       r_fsm, w_fsm_nxt;
  logic [0:127] r_blk;
  logic [0:127] r_rk;
  logic [3:0]   r_cnt;
  logic [0:127] r_de_data;

  logic [0:127] w_fwd_key;
  logic [0:127] w_prev_key;
  logic [0:127] w_t;
  logic [0:127] w_mix;
  logic         w_accept;
  logic         w_hit;

  // KEYX counts 0..9 but consumes rcon[1..10]; ROUND counts 10..1 and undoes
  // the step that used rcon[cnt].
  assign w_fwd_key  = next_key(r_rk, rcon(r_cnt + 4'd1));
  assign w_prev_key = inv_key(r_rk, rcon(r_cnt));
  assign w_t        = inv_sub_shift(r_blk) ^ w_prev_key;
  assign w_mix      = inv_mix(w_t);
  assign de_data    = r_de_data;

`ifdef AES_DEC_KEY_CACHE_EN
  logic [0:127] r_cache_key;
  logic [0:127] r_cache_k10;
  logic         r_cache_v;

  assign w_hit = r_cache_v && (key == r_cache_key);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cache_key <= '0;
      r_cache_k10 <= '0;
      r_cache_v   <= 1'b0;
    end else if (w_accept && !w_hit) begin
      // The new key takes the slot now; it becomes usable once KEYX finishes.
      r_cache_key <= key;
      r_cache_v   <= 1'b0;
    end else if (r_fsm == S_KEYX && r_cnt == 4'd9) begin
      r_cache_k10 <= w_fwd_key;
      r_cache_v   <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          w_accept  = 1'b1;
          w_fsm_nxt = w_hit ? S_ROUND : S_KEYX;
        end
      end
      S_KEYX:  if (r_cnt == 4'd9) w_fsm_nxt = S_ROUND;
      S_ROUND: if (r_cnt == 4'd1) w_fsm_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk     <= '0;
      r_rk      <= '0;
      r_cnt     <= '0;
      r_de_data <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
`ifdef AES_DEC_KEY_CACHE_EN
            if (w_hit) begin
              r_blk <= data ^ r_cache_k10;
              r_rk  <= r_cache_k10;
              r_cnt <= 4'd10;
            end else begin
              r_blk <= data;
              r_rk  <= key;
              r_cnt <= 4'd0;
            end
`else
            r_blk <= data;
            r_rk  <= key;
            r_cnt <= 4'd0;
`endif
          end
        end
        S_KEYX: begin
          r_rk  <= w_fwd_key;
          r_cnt <= r_cnt + 4'd1;
          // Final schedule step: fold in the initial AddRoundKey with K10.
          if (r_cnt == 4'd9) r_blk <= r_blk ^ w_fwd_key;
        end
        S_ROUND: begin
          r_rk  <= w_prev_key;
          r_cnt <= r_cnt - 4'd1;
          // The last round has no InvMixColumns.
          r_blk <= (r_cnt == 4'd1) ? w_t : w_mix;
          if (r_cnt == 4'd1) r_de_data <= w_t;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
